// File: rtl/ini_seq_ctrl.sv
// rtl/ini_seq_ctrl.sv - initialization sequencer: RAM zero-fill, config header read and check
//
// Optional feature macro: INI_CHKSUM_EN (payload reads + 16-bit additive checksum).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_ini_start                     start pulse, accepted in IDLE only
//   o_ini_done / o_ini_fail         one-cycle result pulses
//   o_ini_busy                      sequence in progress (through the result pulse)
//   om_fail_code                    00 none, 01 magic, 10 checksum, 11 timeout
//   o_clr_we, om_clr_addr, om_clr_data   RAM zero-fill write port
//   o_cfg_rd_req, om_cfg_rd_addr    config read request / address
//   i_cfg_rd_ack, im_cfg_rd_data    config read acknowledge / data (same cycle)
module ini_seq_ctrl #(
  parameter int          RAM_AW    = 10,
  parameter int          RAM_DEPTH = 1024,
  parameter int          CFG_AW    = 12,
  parameter int          CFG_LEN   = 8,
  parameter logic [15:0] HDR_MAGIC = 16'hA55A,
  parameter int          TIMEOUT   = 5000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ini_start,
  output logic              o_ini_done,
  output logic              o_ini_fail,
  output logic              o_ini_busy,
  output logic [1:0]        om_fail_code,
  output logic              o_clr_we,
  output logic [RAM_AW-1:0] om_clr_addr,
  output logic [15:0]       om_clr_data,
  output logic              o_cfg_rd_req,
  output logic [CFG_AW-1:0] om_cfg_rd_addr,
  input  logic              i_cfg_rd_ack,
  input  logic [15:0]       im_cfg_rd_data
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RD_REQ, S_RD_GAP, S_CHK, S_DONE, S_FAIL
  } state_t;

  state_t            state, state_nxt;
  logic [RAM_AW-1:0] clr_cnt, clr_nxt;
  logic [CFG_AW-1:0] k, k_nxt;
  logic [TO_W-1:0]   to_cnt, to_nxt;
  logic [15:0]       cap, cap_nxt;
  logic [1:0]        code, code_nxt;
`ifdef INI_CHKSUM_EN
  logic [15:0]       sum, sum_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      k       <= '0;
      to_cnt  <= '0;
      cap     <= '0;
      code    <= 2'b00;
`ifdef INI_CHKSUM_EN
      sum     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
      k       <= k_nxt;
      to_cnt  <= to_nxt;
      cap     <= cap_nxt;
      code    <= code_nxt;
`ifdef INI_CHKSUM_EN
      sum     <= sum_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt      = state;
    clr_nxt        = clr_cnt;
    k_nxt          = k;
    to_nxt         = to_cnt;
    cap_nxt        = cap;
    code_nxt       = code;
`ifdef INI_CHKSUM_EN
    sum_nxt        = sum;
`endif
    o_ini_done     = 1'b0;
    o_ini_fail     = 1'b0;
    o_clr_we       = 1'b0;
    om_clr_addr    = '0;
    o_cfg_rd_req   = 1'b0;
    om_cfg_rd_addr = '0;

    case (state)
      S_IDLE: begin
        if (i_ini_start) begin
          state_nxt = S_CLR;
          clr_nxt   = '0;
          k_nxt     = '0;
          to_nxt    = '0;
          code_nxt  = 2'b00;
`ifdef INI_CHKSUM_EN
          sum_nxt   = '0;
`endif
        end
      end
      S_CLR: begin
        o_clr_we    = 1'b1;
        om_clr_addr = clr_cnt;
        clr_nxt     = clr_cnt + RAM_AW'(1);
        if (clr_cnt == RAM_AW'(RAM_DEPTH - 1)) begin
          state_nxt = S_RD_REQ;
          k_nxt     = '0;
        end
      end
      S_RD_REQ: begin
        o_cfg_rd_req   = 1'b1;
        om_cfg_rd_addr = k;
        // ack is checked first so a same-cycle ack beats the timeout limit
        if (i_cfg_rd_ack) begin
          cap_nxt = im_cfg_rd_data;
          to_nxt  = '0;
`ifdef INI_CHKSUM_EN
          // the sum word's idle cycle is spent in CHK, not RD_GAP
          state_nxt = (k == CFG_AW'(CFG_LEN + 1)) ? S_CHK : S_RD_GAP;
`else
          state_nxt = S_RD_GAP;
`endif
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          state_nxt = S_FAIL;
          code_nxt  = 2'b11;
          to_nxt    = '0;
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      S_RD_GAP: begin
        to_nxt = '0;
        if (k == '0) begin
          if (cap != HDR_MAGIC) begin
            state_nxt = S_FAIL;
            code_nxt  = 2'b01;
          end else begin
`ifdef INI_CHKSUM_EN
            k_nxt     = k + CFG_AW'(1);
            state_nxt = S_RD_REQ;
`else
            state_nxt = S_DONE;
`endif
          end
        end else begin
`ifdef INI_CHKSUM_EN
          sum_nxt   = sum + cap;
          k_nxt     = k + CFG_AW'(1);
          state_nxt = S_RD_REQ;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      S_CHK: begin
        to_nxt = '0;
`ifdef INI_CHKSUM_EN
        if (cap == sum) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_FAIL;
          code_nxt  = 2'b10;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      S_DONE: begin
        o_ini_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      S_FAIL: begin
        o_ini_fail = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_ini_busy   = (state != S_IDLE);
  assign om_fail_code = code;
  assign om_clr_data  = 16'h0000;

endmodule

// File: tb/tb_ini_seq_ctrl.sv
// tb/tb_ini_seq_ctrl.sv - directed self-checking bench for ini_seq_ctrl
module tb_ini_seq_ctrl;

`ifdef INI_CHKSUM_EN
  localparam int EXP_END   = 29;
  localparam int EXP_REQS  = 6;
  localparam int EXP_MAXRD = 5;
`else
  localparam int EXP_END   = 19;
  localparam int EXP_REQS  = 1;
  localparam int EXP_MAXRD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ini_start = 1'b0;
  logic        ini_done, ini_fail, ini_busy;
  logic [1:0]  fail_code;
  logic        clr_we;
  logic [3:0]  clr_addr;
  logic [15:0] clr_data;
  logic        cfg_rd_req;
  logic [11:0] cfg_rd_addr;
  logic        cfg_rd_ack;
  logic [15:0] cfg_rd_data;
  logic        ack_en = 1'b1;
  logic [15:0] cfg_mem [0:15];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // zero-wait config responder
  assign cfg_rd_ack  = cfg_rd_req & ack_en;
  assign cfg_rd_data = (cfg_rd_addr < 12'd16) ? cfg_mem[cfg_rd_addr[3:0]] : 16'h0000;

  ini_seq_ctrl #(
    .RAM_AW(4), .RAM_DEPTH(16), .CFG_AW(12), .CFG_LEN(4),
    .HDR_MAGIC(16'hA55A), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_ini_start(ini_start),
    .o_ini_done(ini_done), .o_ini_fail(ini_fail), .o_ini_busy(ini_busy),
    .om_fail_code(fail_code), .o_clr_we(clr_we), .om_clr_addr(clr_addr),
    .om_clr_data(clr_data), .o_cfg_rd_req(cfg_rd_req), .om_cfg_rd_addr(cfg_rd_addr),
    .i_cfg_rd_ack(cfg_rd_ack), .im_cfg_rd_data(cfg_rd_data)
  );

  task automatic load_cfg(input logic [15:0] w0, w1, w2, w3, w4, w5);
    for (int i = 0; i < 16; i++) cfg_mem[i] = 16'h0000;
    cfg_mem[0] = w0; cfg_mem[1] = w1; cfg_mem[2] = w2;
    cfg_mem[3] = w3; cfg_mem[4] = w4; cfg_mem[5] = w5;
  endtask

  // Start sampled at the posedge called cycle 0; the k-th following negedge observes cycle k.
  task automatic run_seq(input int restart_at, output int done_c, output int fail_c,
                         output int n_wr, output int wr_err, output int max_rd,
                         output int req_cnt, output int busy_err, output logic [1:0] code_at1);
    done_c = 0; fail_c = 0; n_wr = 0; wr_err = 0; max_rd = -1;
    req_cnt = 0; busy_err = 0; code_at1 = 2'b00;
    @(negedge clk); ini_start = 1'b1;
    @(posedge clk); #1 ini_start = 1'b0;
    for (int c = 1; c <= 200 && done_c == 0 && fail_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) code_at1 = fail_code;
      ini_start = (c == restart_at);
      if (clr_we) begin
        if (clr_addr != n_wr[3:0] || clr_data != 16'h0000 || c != n_wr + 1) wr_err++;
        n_wr++;
      end
      if (cfg_rd_req) begin
        req_cnt++;
        if (int'(cfg_rd_addr) > max_rd) max_rd = int'(cfg_rd_addr);
      end
      if (!ini_busy) busy_err++;
      if (ini_done) done_c = c;
      if (ini_fail) fail_c = c;
    end
    ini_start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ini_done, ini_fail, ini_busy, clr_we, cfg_rd_req} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {ini_done, ini_fail, ini_busy, clr_we, cfg_rd_req});
    end
    n_tests++;
    if ({fail_code, clr_addr, clr_data, cfg_rd_addr} !== 34'b0) begin
      n_fail++; $display("FAIL reset_buses: code=%b clr_addr=%h clr_data=%h rd_addr=%h expected all 0", fail_code, clr_addr, clr_data, cfg_rd_addr);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (ini_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_autostart: busy=%b expected 0", ini_busy);
    end
  endtask

  task automatic test_good;
    int d, f, nw, we, mr, rq, be; logic [1:0] c1;
    load_cfg(16'hA55A, 16'd1, 16'd2, 16'd3, 16'd4, 16'h000A);
    run_seq(0, d, f, nw, we, mr, rq, be, c1);
    n_tests++; if (d != EXP_END || f != 0) begin n_fail++; $display("FAIL good_done_cycle: done=%0d fail=%0d expected done=%0d fail=0", d, f, EXP_END); end
    n_tests++; if (nw != 16 || we != 0) begin n_fail++; $display("FAIL good_clear_writes: writes=%0d errors=%0d expected 16 and 0", nw, we); end
    n_tests++; if (rq != EXP_REQS || mr != EXP_MAXRD) begin n_fail++; $display("FAIL good_reads: reqs=%0d max_addr=%0d expected %0d and %0d", rq, mr, EXP_REQS, EXP_MAXRD); end
    n_tests++; if (fail_code !== 2'b00 || be != 0) begin n_fail++; $display("FAIL good_code_busy: code=%b busy_gaps=%0d expected 00 and 0", fail_code, be); end
    @(negedge clk);
    n_tests++; if (ini_busy !== 1'b0 || ini_done !== 1'b0) begin n_fail++; $display("FAIL good_after: busy=%b done=%b expected 0 0", ini_busy, ini_done); end
  endtask

  task automatic test_bad_magic;
    int d, f, nw, we, mr, rq, be; logic [1:0] c1;
    load_cfg(16'h1234, 16'd1, 16'd2, 16'd3, 16'd4, 16'h000A);
    run_seq(0, d, f, nw, we, mr, rq, be, c1);
    n_tests++; if (f != 19 || d != 0) begin n_fail++; $display("FAIL magic_fail_cycle: fail=%0d done=%0d expected fail=19 done=0", f, d); end
    n_tests++; if (fail_code !== 2'b01) begin n_fail++; $display("FAIL magic_code: got %b expected 01", fail_code); end
    n_tests++; if (mr != 0 || rq != 1) begin n_fail++; $display("FAIL magic_reads: max_addr=%0d reqs=%0d expected 0 and 1", mr, rq); end
    repeat (5) @(negedge clk);
    n_tests++; if (fail_code !== 2'b01) begin n_fail++; $display("FAIL magic_code_hold: got %b expected 01", fail_code); end
  endtask

`ifdef INI_CHKSUM_EN
  task automatic test_checksum;
    int d, f, nw, we, mr, rq, be; logic [1:0] c1;
    load_cfg(16'hA55A, 16'd1, 16'd2, 16'd3, 16'd4, 16'h000B);
    run_seq(0, d, f, nw, we, mr, rq, be, c1);
    n_tests++; if (f != 29 || d != 0) begin n_fail++; $display("FAIL cksum_bad_cycle: fail=%0d done=%0d expected fail=29 done=0", f, d); end
    n_tests++; if (fail_code !== 2'b10) begin n_fail++; $display("FAIL cksum_bad_code: got %b expected 10", fail_code); end
    load_cfg(16'hA55A, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 16'h0001);
    run_seq(0, d, f, nw, we, mr, rq, be, c1);
    n_tests++; if (d != 29 || f != 0) begin n_fail++; $display("FAIL cksum_wrap: done=%0d fail=%0d expected done=29 fail=0", d, f); end
    n_tests++; if (c1 !== 2'b00) begin n_fail++; $display("FAIL cksum_code_clear: got %b expected 00", c1); end
  endtask
`endif

  task automatic test_timeout;
    int d, f, nw, we, mr, rq, be; logic [1:0] c1;
    load_cfg(16'hA55A, 16'd1, 16'd2, 16'd3, 16'd4, 16'h000A);
    ack_en = 1'b0;
    run_seq(0, d, f, nw, we, mr, rq, be, c1);
    ack_en = 1'b1;
    n_tests++; if (f != 37 || d != 0) begin n_fail++; $display("FAIL timeout_cycle: fail=%0d done=%0d expected fail=37 done=0", f, d); end
    n_tests++; if (rq != 20) begin n_fail++; $display("FAIL timeout_req_len: got %0d expected 20", rq); end
    n_tests++; if (fail_code !== 2'b11) begin n_fail++; $display("FAIL timeout_code: got %b expected 11", fail_code); end
  endtask

  task automatic test_start_during_clr;
    int d, f, nw, we, mr, rq, be, extra; logic [1:0] c1;
    load_cfg(16'hA55A, 16'd1, 16'd2, 16'd3, 16'd4, 16'h000A);
    run_seq(5, d, f, nw, we, mr, rq, be, c1);
    n_tests++; if (c1 !== 2'b00) begin n_fail++; $display("FAIL restart_code_clear: got %b expected 00", c1); end
    n_tests++; if (d != EXP_END || nw != 16) begin n_fail++; $display("FAIL restart_done: done=%0d writes=%0d expected %0d and 16", d, nw, EXP_END); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (ini_busy || ini_done || ini_fail || clr_we) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL restart_single_run: extra active cycles=%0d expected 0", extra); end
  endtask

  task automatic test_reset_mid_clr;
    int d, f, nw, we, mr, rq, be; logic [1:0] c1;
    load_cfg(16'hA55A, 16'd1, 16'd2, 16'd3, 16'd4, 16'h000A);
    @(negedge clk); ini_start = 1'b1;
    @(posedge clk); #1 ini_start = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++; if (clr_we !== 1'b1 || clr_addr !== 4'd3) begin n_fail++; $display("FAIL midclr_active: we=%b addr=%0d expected 1 and 3", clr_we, clr_addr); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({clr_we, ini_busy, cfg_rd_req, ini_done, ini_fail, clr_addr, fail_code} !== 11'b0) begin
      n_fail++; $display("FAIL midclr_async_reset: we=%b busy=%b req=%b addr=%0d code=%b expected all 0", clr_we, ini_busy, cfg_rd_req, clr_addr, fail_code);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (ini_busy !== 1'b0) begin n_fail++; $display("FAIL midclr_no_resume: busy=%b expected 0", ini_busy); end
    run_seq(0, d, f, nw, we, mr, rq, be, c1);
    n_tests++; if (d != EXP_END || f != 0 || we != 0) begin n_fail++; $display("FAIL midclr_rerun: done=%0d fail=%0d wr_err=%0d expected %0d 0 0", d, f, we, EXP_END); end
  endtask

  initial begin
    load_cfg(16'hA55A, 16'd1, 16'd2, 16'd3, 16'd4, 16'h000A);
    test_reset();
    test_good();
    test_bad_magic();
`ifdef INI_CHKSUM_EN
    test_checksum();
`endif
    test_timeout();
    test_good();
    test_start_during_clr();
    test_reset_mid_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ini_seq_ctrl.md
# ini_seq_ctrl

Initialization sequencer that answers the mode controller's `o_ini_start` request and returns the `i_ini_done` / `i_ini_fail` result.
- On a start pulse it zero-fills the run-time data RAM and reads the downloaded configuration header through a req/ack read port.
- It then checks the header magic word and, optionally, a 16-bit additive checksum.
- It finishes with a one-cycle done or fail pulse and a latched fail code for the diagnostics/LED logic.

## Interface
Parameters:
- `RAM_AW`, 10: address width of the data RAM being cleared.
- `RAM_DEPTH`, 1024: number of words cleared, addresses 0..`RAM_DEPTH`-1.
- `CFG_AW`, 12: configuration read-port address width.
- `CFG_LEN`, 8: number of payload words that follow the header.
- `HDR_MAGIC`, 16'hA55A: required value of configuration word 0.
- `TIMEOUT`, 5000: maximum number of cycles `o_cfg_rd_req` may stay high without an ack.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `i_ini_start` input 1: start request, 1-cycle pulse.
- `o_ini_done` output 1: success, 1-cycle pulse.
- `o_ini_fail` output 1: failure, 1-cycle pulse.
- `o_ini_busy` output 1: high from the cycle after an accepted start until the cycle of the done/fail pulse, inclusive.
- `om_fail_code` output 2: 00 none, 01 bad magic, 10 bad checksum, 11 read timeout. Held until the next accepted start.
- `o_clr_we` output 1: RAM write enable.
- `om_clr_addr` output `RAM_AW`: RAM write address.
- `om_clr_data` output 16: RAM write data, constant 0.
- `o_cfg_rd_req` output 1: configuration read request.
- `om_cfg_rd_addr` output `CFG_AW`: read address, stable while the request is high.
- `i_cfg_rd_ack` input 1: read acknowledge; data is valid in the same cycle.
- `im_cfg_rd_data` input 16: read data.

## Operation
States:
- IDLE
- CLR
- RD_REQ
- RD_GAP
- CHK
- DONE
- FAIL

Transitions:
- **IDLE:** `i_ini_start`=1 → CLR, clear `om_fail_code` and the address counter. Start is accepted in IDLE only; in every other state it is ignored.
- **CLR:**
  - `o_clr_we`=1, `om_clr_addr` = counter; the counter increments every cycle.
  - Counter = `RAM_DEPTH`-1 → RD_REQ, read index k=0.
- **RD_REQ:**
  - `o_cfg_rd_req`=1, `om_cfg_rd_addr`=k.
  - The timeout counter increments every cycle the request is high without an ack.
  - Ack → capture data → RD_GAP.
  - Timeout counter reaches `TIMEOUT` with no ack → FAIL, code 11.
  - If ack and the timeout limit occur in the same cycle, the ack wins.
- **RD_GAP:**
  - Request low for exactly one cycle; the timeout counter is cleared.
  - k=0: data ≠ `HDR_MAGIC` → FAIL, code 01. Otherwise continue.
  - Continue with the checksum: k=1..`CFG_LEN` add data to a 16-bit sum (mod 2^16, carry discarded); k = `CFG_LEN`+1 → CHK. Otherwise k+1 → RD_REQ.
  - Continue without the checksum: → DONE.
- **CHK:** captured word `CFG_LEN`+1 == sum → DONE; otherwise → FAIL, code 10.
- **DONE / FAIL:** drive the corresponding pulse for one cycle → IDLE.
- A late ack arriving while the request is low is ignored.

## Timing
Reset:
- All outputs are 0.
- State IDLE; counters, sum and fail code are cleared.
- Reset takes effect immediately and asynchronously, including mid-sequence; the request drops in the same instant.
- After reset a fresh start is required.

Latency (start sampled at cycle 0, zero-wait ack, i.e. ack in the first request cycle):
- RAM writes occur in cycles 1..`RAM_DEPTH`.
- Read k has its request at cycle `RAM_DEPTH`+1+2k.
- The done/fail pulse comes 2 cycles after the final ack: the cycle after the RD_GAP cycle, or after CHK when the checksum is compiled in.
- With the checksum: done at cycle `RAM_DEPTH`+2·`CFG_LEN`+5.
- Without the checksum: done at cycle `RAM_DEPTH`+3.

Each ack wait state adds one cycle per read.

## Configuration
- Macro `INI_CHKSUM_EN`.
- Defined: payload reads, sum accumulation and the CHK state are present; fail code 10 is possible.
- Undefined: only the header word is read; success immediately follows a good magic. The sum logic is not synthesized and code 10 never occurs.

## Test plan
All scenarios use `RAM_DEPTH`=16 and `CFG_LEN`=4, with the checksum compiled in unless stated.
- **Good image, zero-wait ack:** header A55A, payload 1,2,3,4, sum word 000A, start at cycle 0 → 16 zero writes at addresses 0..15 in cycles 1..16; `o_ini_done` pulses at cycle 29; fail code 00.
- **Bad magic:** word 0 = 1234 → `o_ini_fail` pulses at cycle 19, code 01; no read beyond address 0.
- **Bad checksum:** sum word = 000B → fail pulses at cycle 29, code 10.
- **Checksum wrap-around:** payload FFFF,0002,0,0 with sum 0001 → done.
- **Timeout:** no ack with `TIMEOUT`=20 → request high for 20 cycles, then fail with code 11.
- **Corner cases:**
  - Start pulsed during CLR → ignored, single done.
  - `rst_n` low mid-CLR → all outputs 0 at once; a new start yields a normal done.
- **Checksum compiled out:** good header → done at cycle 19.
